// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/ready handshake.
// Produces quotient, remainder and a divide-by-zero flag; STEPS_PER_CYCLE steps per clock.
module seq_divider #(
  parameter int WIDTH           = 12,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || STEPS_PER_CYCLE < 1 || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("seq_divider: WIDTH must be >= 2 and a multiple of STEPS_PER_CYCLE");
  end

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_ready;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_p;
  logic [WIDTH-1:0] w_a;

  // Partial remainder is always < divisor after a restore, so only WIDTH bits are stored;
  // the extra MSB exists only inside the step to catch the borrow.
  always_comb begin
    w_p = {1'b0, r_p};
    w_a = r_a;
    for (int unsigned s = 0; s < STEPS_PER_CYCLE; s++) begin
      w_p = {w_p[WIDTH-1:0], w_a[WIDTH-1]};
      w_a = w_a << 1;
      w_p = w_p - {1'b0, r_b};
      if (w_p[WIDTH]) begin
        w_a[0] = 1'b0;
        w_p    = w_p + {1'b0, r_b};
      end else begin
        w_a[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_p           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_ready       <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= dividend;
            r_b   <= divisor;
            r_p   <= '0;
            r_cnt <= '0;
            if (divisor != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_quotient    <= '0;
              r_remainder   <= dividend;
              r_div_by_zero <= 1'b1;
              r_ready       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a;
          r_p   <= w_p[WIDTH-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_quotient    <= w_a;
            r_remainder   <= w_p[WIDTH-1:0];
            r_div_by_zero <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign ready       = r_ready;
  assign div_by_zero = r_div_by_zero;

endmodule
